// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: counter state names,
// default counter type and reset value, and the saturating update rule.
package bht_pkg;

    // Named states of the default 2-bit counter.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_e;

    typedef logic [1:0] cnt_t;

    localparam cnt_t INIT_VAL_DEFAULT = WT;

    // Saturating step of a counter that is `width` bits wide.
    // The value is carried in 32 bits so that one function serves every width.
    function automatic logic [31:0] sat_update(input logic [31:0] cnt,
                                               input logic        taken,
                                               input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        if (taken) begin
            return (cnt >= max_val) ? max_val : cnt + 32'd1;
        end
        return (cnt == '0) ? '0 : cnt - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Combinational next value of a saturating counter on a resolved branch.
module sat_counter_next
    import bht_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             taken,
    output logic [WIDTH-1:0] cnt_next
);

    // Increment on taken, decrement on not-taken, clamped at both ends.
    always_comb begin
        cnt_next = WIDTH'(sat_update(32'(cnt), taken, WIDTH));
    end

endmodule

// File: rtl/branch_history_table.sv
// Table of saturating branch predictors indexed by PC, with a registered
// predict port and an independent update port.
// Optional global-history (gshare) indexing is enabled by BHT_GSHARE_EN.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter logic [CNT_WIDTH-1:0] INIT_VAL = CNT_WIDTH'(INIT_VAL_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pred_req,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [CNT_WIDTH-1:0]  pred_counter,
`ifdef BHT_GSHARE_EN
    output logic [INDEX_BITS-1:0] pred_hist,
    input  logic [INDEX_BITS-1:0] upd_hist,
`endif
    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic                  upd_taken
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;

    logic [CNT_WIDTH-1:0]  tbl [ENTRIES];
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CNT_WIDTH-1:0]  upd_cnt_next;

    // Only the word-aligned index bits select an entry; the rest alias freely.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0],
                              upd_pc[PC_WIDTH-1:INDEX_BITS+2], upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    // Index computation hashes the PC slice with global history.
    always_comb begin
        pred_idx = pred_pc[INDEX_BITS+1:2] ^ ghr;
        upd_idx  = upd_pc[INDEX_BITS+1:2] ^ upd_hist;
    end

    // Global history shifts in each resolved outcome.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= INDEX_BITS'({ghr, upd_taken});
        end
    end

    // History used by a lookup is registered alongside the prediction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_hist <= '0;
        end else if (pred_req) begin
            pred_hist <= ghr;
        end
    end
`else
    // Index computation from the plain PC slice.
    always_comb begin
        pred_idx = pred_pc[INDEX_BITS+1:2];
        upd_idx  = upd_pc[INDEX_BITS+1:2];
    end
`endif

    sat_counter_next #(
        .WIDTH(CNT_WIDTH)
    ) u_sat_counter_next (
        .cnt      (tbl[upd_idx]),
        .taken    (upd_taken),
        .cnt_next (upd_cnt_next)
    );

    // Counter table: reset to INIT_VAL, one saturating write per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl[i] <= INIT_VAL;
            end
        end else if (upd_valid) begin
            tbl[upd_idx] <= upd_cnt_next;
        end
    end

    // Registered lookup; reads the pre-update value when indices collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_valid   <= 1'b0;
            pred_taken   <= 1'b0;
            pred_counter <= '0;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                pred_counter <= tbl[pred_idx];
                pred_taken   <= tbl[pred_idx][CNT_WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table (default build, 64 x 2-bit).
module tb_branch_history_table;

    logic        clk;
    logic        reset;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_counter;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    int checks = 0;
    int errors = 0;

    // Reference model: one integer counter per entry, clamped to 0..3.
    int model [64];
    int exp_valid;
    int last_cnt;

    branch_history_table #(
        .PC_WIDTH(32),
        .INDEX_BITS(6),
        .CNT_WIDTH(2),
        .INIT_VAL(2'b10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pred_req     (pred_req),
        .pred_pc      (pred_pc),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_counter (pred_counter),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int entry_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 2;
        exp_valid = 0;
        last_cnt  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},   32'(pred_valid),   32'(exp_valid));
        check({tag, ".counter"}, 32'(pred_counter), 32'(last_cnt));
        check({tag, ".taken"},   32'(pred_taken),   32'(last_cnt >= 2));
    endtask

    // One clock cycle of stimulus, entered away from the rising edge.
    task automatic step(input string tag, input logic req, input logic [31:0] ppc,
                        input logic uv, input logic [31:0] upc, input logic ut);
        int seen;
        pred_req  = req;
        pred_pc   = ppc;
        upd_valid = uv;
        upd_pc    = upc;
        upd_taken = ut;
        seen = model[entry_of(ppc)];
        @(posedge clk);
        if (uv) begin
            if (ut) model[entry_of(upc)] = (model[entry_of(upc)] + 1 > 3) ? 3 : model[entry_of(upc)] + 1;
            else    model[entry_of(upc)] = (model[entry_of(upc)] - 1 < 0) ? 0 : model[entry_of(upc)] - 1;
        end
        exp_valid = req ? 1 : 0;
        if (req) last_cnt = seen;
        #1;
        check_outputs(tag);
        pred_req  = 1'b0;
        upd_valid = 1'b0;
    endtask

    // Asynchronous reset pulse between two rising edges.
    task automatic reset_pulse(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        pred_req  = 1'b0;
        pred_pc   = '0;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        model_reset();

        #7;
        check_outputs("reset_state");
        #5;
        reset = 1'b1;

        // Basic lookup after reset, then idle holds the last value.
        step("lookup_init", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        step("idle_hold",   1'b0, 32'h100, 1'b0, 32'h0, 1'b0);

        // Saturation at the top, then at the bottom.
        for (int i = 0; i < 4; i++) step("upd_taken", 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
        step("lookup_sat_hi", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step("upd_nt", 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        step("lookup_sat_lo", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);

        // Same-index predict and update: no bypass, visible next cycle.
        reset_pulse("reset_mid1");
        step("collide",      1'b1, 32'h104, 1'b1, 32'h104, 1'b0);
        step("collide_next", 1'b1, 32'h104, 1'b0, 32'h0,   1'b0);

        // Upper PC bits alias onto the same entry; low two bits ignored.
        step("alias_upd",    1'b0, 32'h0,   1'b1, 32'h100, 1'b1);
        step("alias_lookup", 1'b1, 32'h203, 1'b0, 32'h0,   1'b0);
        step("other_entry",  1'b1, 32'h104, 1'b0, 32'h0,   1'b0);

        // Update held across an edge while reset is asserted is dropped.
        #2;
        upd_valid = 1'b1;
        upd_pc    = 32'h100;
        upd_taken = 1'b0;
        reset     = 1'b0;
        model_reset();
        #1;
        check_outputs("reset_mid2");
        @(posedge clk);
        #2;
        reset     = 1'b1;
        upd_valid = 1'b0;
        step("after_reset", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);

        // Randomized traffic over a small PC window to force collisions.
        for (int i = 0; i < 400; i++) begin
            step("random",
                 1'($urandom_range(0, 1)), $urandom & 32'h3ff,
                 1'($urandom_range(0, 1)), $urandom & 32'h3ff,
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
- Parametrised successor to the single 2-bit predictor FSM.
- Holds a table of 2^INDEX_BITS saturating counters of CNT_WIDTH bits each, indexed by branch PC.
- Has an independent predict port (registered, 1-cycle latency) and update port (resolved outcome from EX stage).
- Sits beside IF: IF issues lookups; EX writes back actual outcomes.

Parameters:
- PC_WIDTH, 32, width of the PC buses; must be >= INDEX_BITS+2.
- INDEX_BITS, 6, log2 of the entry count (default 64 entries).
- CNT_WIDTH, 2, counter width; must be >= 1. Predict taken when the counter MSB is 1.
- INIT_VAL, 2'b10, reset value of every counter (weakly taken); must fit in CNT_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pred_req  in  1  lookup request this cycle
- pred_pc  in  PC_WIDTH  PC of the fetched instruction
- pred_valid  out  1  pred_* outputs valid (one cycle after pred_req)
- pred_taken  out  1  MSB of the looked-up counter
- pred_counter  out  CNT_WIDTH  raw value of the looked-up counter
- upd_valid  in  1  resolved branch this cycle
- upd_pc  in  PC_WIDTH  PC of the resolved branch
- upd_taken  in  1  actual outcome: 1 = taken

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low, on port reset.
- Reset state:
  - All counters = INIT_VAL.
  - pred_valid = 0, pred_taken = 0, pred_counter = 0.
- Index: idx = pc[INDEX_BITS+1:2]. PC bits [1:0] are ignored. Upper PC bits alias, with no tag check.
- Predict:
  - On a clk edge with pred_req = 1, register pred_valid = 1, pred_counter = table[idx(pred_pc)], pred_taken = that value's MSB.
  - On a clk edge with pred_req = 0: pred_valid = 0; pred_taken and pred_counter hold their last values.
  - Latency is exactly 1 cycle. No back-pressure; a request every cycle is legal.
- Update:
  - On a clk edge with upd_valid = 1, table[idx(upd_pc)] saturates.
  - If upd_taken = 1: increment, capped at 2^CNT_WIDTH-1.
  - If upd_taken = 0: decrement, floored at 0.
  - Only one entry is written per cycle.
- Counter transition for CNT_WIDTH = 2:
  - taken: 00->01, 01->10, 10->11, 11->11.
  - not-taken: 11->10, 10->01, 01->00, 00->00.
- Simultaneous predict and update to the same index in one cycle: the prediction returns the pre-update value (no bypass). The updated value is visible to a lookup issued on the following cycle.
- Simultaneous predict and update to different indices: the two operations are independent.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). An update in flight on that edge is discarded.
- No X is allowed on pred_* after reset, whatever the inputs.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- Defined:
  - Adds a global history register ghr[INDEX_BITS-1:0], reset 0.
  - Prediction index = pc[INDEX_BITS+1:2] ^ ghr.
  - Adds output pred_hist[INDEX_BITS]: the ghr value used for the lookup, registered alongside pred_*.
  - Adds input upd_hist[INDEX_BITS]. Update index = upd_pc[INDEX_BITS+1:2] ^ upd_hist.
  - On upd_valid, ghr <= {ghr[INDEX_BITS-2:0], upd_taken}.
  - On the same edge the lookup uses the old ghr.
- Undefined:
  - No ghr, no pred_hist, no upd_hist.
  - Index is the plain PC slice described above.

Decomposition:
- Shared package, bht_pkg:
  - Counter state constants SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11, plus a counter typedef for the default width.
  - Default INIT_VAL.
  - Function sat_update(cnt, taken) parametrised by width.
- One natural sub-module, sat_counter_next: combinational saturating next-value logic, instantiated once on the update path.
- The table array, registers and ghr live in the top.

Test Plan:
1. Reset, then lookup at PC 0x100 -> next cycle pred_valid = 1, pred_counter = 2'b10, pred_taken = 1. With pred_req held low afterwards, pred_valid = 0.
2. Four updates taken at 0x100, then lookup -> pred_counter = 2'b11 (saturated). Then five updates not-taken -> pred_counter = 2'b00, pred_taken = 0.
3. Lookup and update (not-taken) to 0x104 in the same cycle from reset -> pred_counter = 2'b10. A lookup on the next cycle -> 2'b01.
4. Update taken at 0x100, then lookup at 0x200 (idx 0 vs 0 with INDEX_BITS = 6, i.e. aliasing) -> pred_counter = 2'b11. Lookup at 0x104 -> 2'b10 (unaffected).
5. Assert reset for a partial cycle between edges after updates -> pred_* = 0 immediately. A subsequent lookup at any PC returns 2'b10.
6. With BHT_GSHARE_EN: three taken updates (ghr = 3'b111 in the low bits), then lookup at 0x100 -> pred_hist = 6'b000111 and index 7 is read. An update using upd_hist = 6'b000111 modifies only entry 7.
